// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// HALT_INST is the same opcode the decode and control units treat as the halt instruction.
package imem_loader_pkg;

  localparam int NB_BYTE = 8;
  localparam int NB_INST = 32;
  localparam int MEM_DEPTH_DEFAULT = 128;
  localparam logic [31:0] HALT_INST = 32'hF800_0000;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDRWIDTH = addr_width(MEM_DEPTH_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs NB_BYTE-wide stream bytes big-endian into one instruction word.
// word_complete fires in the same cycle the last byte of a word is accepted.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int NB_INST = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [NB_BYTE-1:0] data,
  output logic [NB_INST-1:0] word_next,
  output logic               word_complete
);

  localparam logic [1:0] LAST = 2'(NB_INST / NB_BYTE - 1);

  logic [NB_INST-1:0] shift;
  logic [1:0]         count;

  // The first byte shifts all the way up to the top of the word.
  assign word_next     = {shift[NB_INST-NB_BYTE-1:0], data};
  assign word_complete = accept && (count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      shift <= '0;
      count <= 2'd0;
    end else if (accept) begin
      shift <= word_next;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Write-side front end for instruction memory: packs a byte stream into words
// and writes them sequentially from address 0 until HALT or memory full.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int NB_INST   = 32,
  parameter int NB_BYTE   = imem_loader_pkg::NB_BYTE,
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W    = addr_width(MEM_DEPTH),
  parameter logic [NB_INST-1:0] HALT_WORD = HALT_INST
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [NB_INST-1:0] o_wr_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [ADDR_W:0]    o_word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  loader_state_t      state;
  logic [ADDR_W-1:0]  addr;
  logic               accept;
  logic               arm;
  logic [NB_INST-1:0] word_next;
  logic               word_complete;

  assign o_rx_ready = (state == ST_RECV);
  assign o_busy     = (state == ST_RECV) || (state == ST_WRITE);
  assign accept     = i_rx_valid && o_rx_ready;
  assign arm        = i_start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

  imem_loader_byte_packer #(
    .NB_INST (NB_INST),
    .NB_BYTE (NB_BYTE)
  ) u_packer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .clear         (arm),
    .accept        (accept),
    .data          (i_rx_data),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  // HALT is checked before the full-memory test so a HALT in the last slot still finishes cleanly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      addr         <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            addr         <= '0;
            o_word_count <= '0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            state        <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (word_complete) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= addr;
            o_wr_data <= word_next;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          o_word_count <= o_word_count + (ADDR_W+1)'(1);
          if (o_wr_data == HALT_WORD) begin
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else if (addr == LAST_ADDR) begin
            o_overflow <= 1'b1;
            state      <= ST_ERROR;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= ST_RECV;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side front end for the instruction memory.
- Consumes a byte stream (from the UART/debug receive path) through a valid/ready handshake.
- Packs every 4 bytes into one 32-bit instruction and issues single-cycle writes at sequential addresses starting at 0.
- Stops at the HALT instruction, or flags overflow when memory fills without one.

Parameters:
NB_INST, 32, instruction width in bits; fixed multiple of 8.
NB_BYTE, 8, stream byte width.
MEM_DEPTH, 128, instruction memory depth in words.
ADDR_W, 7, write address width; equals clog2(MEM_DEPTH).
HALT_WORD, 32'hF800_0000, terminating instruction; equals the memory init pattern.

Ports:
i_clk  in  1  clock; all state changes on posedge.
i_reset  in  1  synchronous, active-high reset.
i_start  in  1  arm loader; honoured only in IDLE, DONE or ERROR.
i_rx_data  in  NB_BYTE  incoming byte.
i_rx_valid  in  1  byte present on i_rx_data.
o_rx_ready  out  1  loader can accept a byte this cycle.
o_wr_en  out  1  memory write strobe, one cycle per word.
o_wr_addr  out  ADDR_W  word address of current write.
o_wr_data  out  NB_INST  assembled instruction.
o_busy  out  1  high in RECV and WRITE.
o_done  out  1  HALT written; sticky until i_start or reset.
o_overflow  out  1  memory full without HALT; sticky until i_start or reset.
o_word_count  out  ADDR_W+1  words written in current load, HALT included.

Behaviour:
- Reset: state=IDLE. o_rx_ready, o_wr_en, o_busy, o_done and o_overflow are 0. o_wr_addr, o_wr_data and o_word_count are 0. Byte counter is 0 and the partial word is cleared.
- Reset has priority over every other input, including mid-load.
  - A partial word is discarded.
  - No write issues in the reset cycle or the cycle after it.
- All outputs are registered except o_rx_ready and o_busy, which decode directly from state.
- States:
  - IDLE: ready=0. On i_start: clear addr, byte counter, word count, done and overflow, then go to RECV.
  - RECV: ready=1. A byte is accepted on a posedge where i_rx_valid && o_rx_ready.
    - Big-endian packing: first byte goes to bits [31:24], fourth byte to [7:0].
    - Byte counter counts 0..3. Accepting the 4th byte moves the state to WRITE. i_rx_valid gaps of any length are tolerated.
  - WRITE: lasts exactly one cycle. ready=0 and o_wr_en=1, with o_wr_addr=addr and o_wr_data=word.
    - o_word_count increments at the end of the cycle.
    - If word==HALT_WORD, go to DONE.
    - Else if addr==MEM_DEPTH-1, go to ERROR.
    - Else addr+1 and go back to RECV.
  - DONE: o_done=1 and ready=0. On i_start, re-arm as from IDLE.
  - ERROR: o_overflow=1 and ready=0. On i_start, re-arm as from IDLE.
- Latency: 4th byte accepted at edge N; o_wr_en is high during cycle N+1 and sampled by memory at edge N+1. Minimum 5 cycles per word.
- o_wr_addr and o_wr_data hold their last values outside WRITE. o_wr_en is 0 outside WRITE.
- i_start while busy (RECV or WRITE) is ignored.
- i_start and i_rx_valid asserted together in IDLE: the byte is not accepted, because ready=0 in that cycle.
- HALT written at addr MEM_DEPTH-1 goes to DONE, not ERROR; HALT check has priority.
- Address never wraps. No write ever targets an address of MEM_DEPTH or above.

Decomposition:
- Shared header holds:
  - HALT opcode constant, shared with the decode and control units.
  - NB_BYTE.
  - Loader state encodings: IDLE=0, RECV=1, WRITE=2, DONE=3, ERROR=4, 3-bit.
  - ADDRWIDTH derivation.
- One natural sub-module: byte_packer, containing the shift register, the 2-bit byte counter and a word_complete pulse. The FSM and address counter stay in imem_loader.

Test Plan:
- Two-word load: reset, i_start, bytes 20 01 00 05 | 20 02 00 07 | F8 00 00 00 sent back-to-back. Required response:
  - Writes (0,0x20010005), (1,0x20020007) and (2,0xF8000000), each with o_wr_en high exactly 1 cycle.
  - o_done=1 and o_word_count=3.
- Backpressure gaps: same stream with 0-3 idle cycles randomly inserted between i_rx_valid pulses -> identical writes and addresses; no byte lost or duplicated.
- Overflow: MEM_DEPTH=4, ADDR_W=2, four non-HALT words 0x00000001..4 -> writes at addr 0..3, then o_overflow=1, o_done=0, ready=0. Further bytes are not accepted.
- Mid-word reset: after 2 bytes of a word, pulse i_reset for 1 cycle. Required response:
  - No write issued; all outputs return to reset values.
  - After i_start, a new word 0xF8000000 is written at addr 0.
- Start while busy: pulse i_start after byte 3 of word 1 -> ignored; the load continues and addr increments normally.
- Re-arm after DONE: i_start from DONE clears o_done and o_word_count; the next word writes at addr 0.
